// File: rtl/imm_ext_pipe.sv
// Pipelined immediate generator for the MIPS decode/execute path (SEXT/ZEXT/UPPER/BRANCH/JUMP).
// Optional macro IMM_EXT_ILLEGAL_EN adds an illegal_mode output for reserved mode codes.
module imm_ext_pipe #(
    parameter int INSTR_W  = 32,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int JT_W     = 26,
    parameter int SHIFT_BR = 2,
    parameter int STAGES   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic [2:0]         mode,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    output logic [OUT_W-1:0]   imm_out,
`ifdef IMM_EXT_ILLEGAL_EN
    output logic               illegal_mode,
`endif
    output logic               out_neg
);

    generate
        if (STAGES < 1 || STAGES > 4 || OUT_W < IN_W || OUT_W > 64) begin : g_param_err
            $error("imm_ext_pipe: illegal parameters STAGES=%0d IN_W=%0d OUT_W=%0d", STAGES, IN_W, OUT_W);
        end
    endgenerate

    typedef enum logic [2:0] {
        M_SEXT   = 3'b000,
        M_ZEXT   = 3'b001,
        M_UPPER  = 3'b010,
        M_BRANCH = 3'b011,
        M_JUMP   = 3'b100
    } mode_e;

    logic [IN_W-1:0]       f;
    logic [OUT_W-1:0]      sext, zext, upper, branch, jump;
    logic [OUT_W+IN_W-1:0] upper_wide;
    logic [OUT_W-1:0]      imm_d;
    logic                  ill_d;
    logic                  unused_instr;

    assign f            = instr[IN_W-1:0];
    assign sext         = OUT_W'($signed(f));
    assign zext         = OUT_W'(f);
    // Field sits on top of OUT_W zeros; the top OUT_W bits are the UPPER result.
    assign upper_wide   = {f, {OUT_W{1'b0}}};
    assign upper        = upper_wide[OUT_W+IN_W-1:IN_W];
    assign branch       = sext << SHIFT_BR;
    assign jump         = OUT_W'(instr[JT_W-1:0]) << SHIFT_BR;
    assign unused_instr = ^instr;

    always_comb begin
        imm_d = sext;
        ill_d = 1'b0;
        case (mode)
            M_SEXT:   imm_d = sext;
            M_ZEXT:   imm_d = zext;
            M_UPPER:  imm_d = upper;
            M_BRANCH: imm_d = branch;
            M_JUMP:   imm_d = jump;
            default: begin
`ifdef IMM_EXT_ILLEGAL_EN
                imm_d = '0;
                ill_d = 1'b1;
`else
                imm_d = sext;
`endif
            end
        endcase
    end

    logic [STAGES-1:0]            vld_pipe;
    logic [STAGES-1:0][OUT_W-1:0] data_pipe;
    logic [STAGES-1:0]            ill_pipe;

    // Flush only drops valid bits; data is don't-care while invalid so it simply holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
            ill_pipe  <= '0;
        end else if (flush) begin
            vld_pipe  <= '0;
        end else if (!stall) begin
            vld_pipe[0]  <= in_valid;
            data_pipe[0] <= imm_d;
            ill_pipe[0]  <= ill_d;
            for (int k = 1; k < STAGES; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                data_pipe[k] <= data_pipe[k-1];
                ill_pipe[k]  <= ill_pipe[k-1];
            end
        end
    end

    assign out_valid = vld_pipe[STAGES-1];
    assign imm_out   = data_pipe[STAGES-1];
    assign out_neg   = data_pipe[STAGES-1][OUT_W-1];
`ifdef IMM_EXT_ILLEGAL_EN
    assign illegal_mode = ill_pipe[STAGES-1];
`else
    logic unused_ill;
    assign unused_ill = ^ill_pipe;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench: three pipelines (STAGES 1/2/3) share stimulus and are checked
// against a queue-of-entries reference model plus directed constant checks.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  mode = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        ov [3];
    logic [31:0] od [3];
    logic        on [3];
    logic        oi [3];

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imm_ext_pipe #(.STAGES(g + 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .mode(mode),
            .stall(stall), .flush(flush), .out_valid(ov[g]), .imm_out(od[g]),
`ifdef IMM_EXT_ILLEGAL_EN
            .illegal_mode(oi[g]),
`endif
            .out_neg(on[g])
        );
`ifndef IMM_EXT_ILLEGAL_EN
        assign oi[g] = 1'b0;
`endif
    end

    // Reference model: list of accepted entries, each aging one step per unstalled edge.
    typedef struct {
        int          inst;
        int          age;
        logic [31:0] val;
        logic        ill;
    } ent_t;

    ent_t        q[$];
    logic        exp_v [3];
    logic [31:0] exp_d [3];
    logic        exp_i [3];
    logic        rst_seen;

    function automatic logic [32:0] ref_imm(input logic [2:0] m, input logic [31:0] ins);
        logic [63:0] s;
        logic [63:0] r;
        logic        il;
        s  = {{48{ins[15]}}, ins[15:0]};
        il = 1'b0;
        case (m)
            3'd0: r = s;
            3'd1: r = {48'd0, ins[15:0]};
            3'd2: r = {48'd0, ins[15:0]} * 64'd65536;
            3'd3: r = s * 64'd4;
            3'd4: r = {38'd0, ins[25:0]} * 64'd4;
            default: begin
`ifdef IMM_EXT_ILLEGAL_EN
                r  = 64'd0;
                il = 1'b1;
`else
                r  = s;
`endif
            end
        endcase
        return {il, r[31:0]};
    endfunction

    task automatic model_edge();
        logic [32:0] res;
        ent_t        e;
        rst_seen = 1'b0;
        if (!rst_n) begin
            q.delete();
            rst_seen = 1'b1;
            for (int i = 0; i < 3; i++) begin
                exp_v[i] = 1'b0; exp_d[i] = '0; exp_i[i] = 1'b0;
            end
        end else if (flush) begin
            q.delete();
            for (int i = 0; i < 3; i++) exp_v[i] = 1'b0;
        end else if (!stall) begin
            for (int i = 0; i < 3; i++) exp_v[i] = 1'b0;
            if (in_valid) begin
                res = ref_imm(mode, instr);
                for (int i = 0; i < 3; i++) q.push_back('{i, 0, res[31:0], res[32]});
            end
            for (int k = q.size() - 1; k >= 0; k--) begin
                e = q[k];
                e.age++;
                q[k] = e;
                if (e.age == e.inst + 1) begin
                    exp_v[e.inst] = 1'b1;
                    exp_d[e.inst] = e.val;
                    exp_i[e.inst] = e.ill;
                    q.delete(k);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid[s%0d]", i + 1), {31'd0, ov[i]}, {31'd0, exp_v[i]});
            if (exp_v[i] || rst_seen) begin
                chk($sformatf("imm[s%0d]", i + 1), od[i], exp_d[i]);
                chk($sformatf("neg[s%0d]", i + 1), {31'd0, on[i]}, {31'd0, exp_d[i][31]});
                chk($sformatf("ill[s%0d]", i + 1), {31'd0, oi[i]}, {31'd0, exp_i[i]});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_all();
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [31:0] ins);
        in_valid = v; mode = m; instr = ins;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            exp_v[i] = 1'b0; exp_d[i] = '0; exp_i[i] = 1'b0;
        end
        rst_seen = 1'b0;

        // Reset
        rst_n = 1'b0;
        step(); step();
        chk("rst_imm", od[2], 32'h0);
        rst_n = 1'b1;

        // Mode sweep, 1-cycle latency on the STAGES=1 instance
        drive(1, 3'd0, 32'h00008001); step();
        chk("t1_sext", od[0], 32'hFFFF8001); chk("t1_sext_neg", {31'd0, on[0]}, 32'd1);
        drive(1, 3'd1, 32'h00008001); step();
        chk("t1_zext", od[0], 32'h00008001); chk("t1_zext_neg", {31'd0, on[0]}, 32'd0);
        drive(1, 3'd2, 32'h00008001); step();
        chk("t1_upper", od[0], 32'h80010000);
        drive(1, 3'd3, 32'h00008001); step();
        chk("t1_branch", od[0], 32'hFFFE0004);
        drive(1, 3'd4, 32'h0BFFFFFF); step();
        chk("t2_jump", od[0], 32'h0FFFFFFC);
        drive(1, 3'd3, 32'h0000FFFF); step();
        chk("t2_branch", od[0], 32'hFFFFFFFC);
        drive(0, 3'd0, 32'h0); step(); step(); step();

        // STAGES=3 stream with a 2-cycle stall
        drive(1, 3'd0, 32'h7FFF); step();
        drive(1, 3'd0, 32'h8000); step();
        drive(1, 3'd0, 32'h0001); step();
        chk("t3_first", od[2], 32'h00007FFF); chk("t3_first_v", {31'd0, ov[2]}, 32'd1);
        drive(0, 3'd0, 32'h0); stall = 1'b1; step(); step();
        chk("t3_hold", od[2], 32'h00007FFF);
        stall = 1'b0; step();
        chk("t3_second", od[2], 32'hFFFF8000);
        step();
        chk("t3_third", od[2], 32'h00000001);
        step();
        chk("t3_drained", {31'd0, ov[2]}, 32'd0);

        // Flush with stall while two entries are in flight
        drive(1, 3'd1, 32'h1111); step();
        drive(1, 3'd1, 32'h2222); step();
        drive(1, 3'd1, 32'h3333); stall = 1'b1; flush = 1'b1; step();
        chk("t4_flushed", {31'd0, ov[2]}, 32'd0);
        stall = 1'b0; flush = 1'b0; drive(0, 3'd0, 32'h0); step(); step(); step();
        chk("t4_quiet", {31'd0, ov[2]}, 32'd0);
        drive(1, 3'd2, 32'h4444); step(); drive(0, 3'd0, 32'h0); step(); step();
        chk("t4_after", od[2], 32'h44440000);

        // Reset mid-stream
        drive(1, 3'd0, 32'hAAAA); step();
        drive(1, 3'd0, 32'hBBBB); rst_n = 1'b0; stall = 1'b1; step();
        chk("t5_rst_v", {31'd0, ov[1]}, 32'd0); chk("t5_rst_imm", od[1], 32'h0);
        rst_n = 1'b1; stall = 1'b0; drive(0, 3'd0, 32'h0);
        for (int i = 0; i < 4; i++) step();

        // Reserved mode
        drive(1, 3'd5, 32'h00001234); step();
`ifdef IMM_EXT_ILLEGAL_EN
        chk("t6_imm", od[0], 32'h0); chk("t6_ill", {31'd0, oi[0]}, 32'd1);
`else
        chk("t6_imm", od[0], 32'h00001234);
`endif
        drive(0, 3'd0, 32'h0); step(); step(); step();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom);
            stall = ($urandom_range(0, 6) == 0);
            flush = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0; drive(0, 3'd0, 32'h0);
        step(); step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
